perm_rf_fwd: RTL and testbench
==============================

Name: perm_rf_fwd

Overview:
- Register-fetch/forward stage directly upstream of the Permute execution pipe.
- Holds the 128x128-bit register table and reads ra/rb for the instruction presented by decode, bypassing the Permute writeback value into the read.
- Detects read-after-write hazards against instructions in flight in Permute, stalls decode, and injects nops.
- Drives a registered instruction bundle that Permute consumes one cycle later.

Parameters:
- NUM_REGS, 128, register table depth.
- DATA_W, 128, register width in bits.
- ADDR_W, 7, register address width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- dec_valid  in  1  decode presents a valid instruction this cycle.
- dec_op  in  11  decoded opcode [0:10].
- dec_format  in  3  instruction format.
- dec_rt_addr  in  7  destination address [0:6].
- dec_ra_addr  in  7  source A address.
- dec_rb_addr  in  7  source B address.
- dec_uses_rb  in  1  instruction reads rb; format 2 clears it.
- dec_imm  in  18  immediate [0:17].
- dec_reg_write  in  1  instruction writes the register table.
- branch_taken  in  1  flush: squash the decode instruction and the output register.
- rt_wb  in  128  Permute writeback value.
- rt_addr_wb  in  7  Permute writeback address.
- reg_write_wb  in  1  Permute writeback enable.
- rt_addr_delay  in  4x7  Permute staging addresses, index 0 youngest.
- reg_write_delay  in  4  Permute staging write enables.
- stall  out  1  combinational; decode holds its outputs while high.
- op  out  11  to Permute, registered.
- format  out  3  to Permute, registered.
- rt_addr  out  7  to Permute, registered.
- ra  out  128  to Permute, registered.
- rb  out  128  to Permute, registered.
- imm  out  18  to Permute, registered.
- reg_write  out  1  to Permute, registered.

Behaviour:
- Reset (asynchronous):
  - All 128 register-table entries cleared to 0.
  - All outputs registered to 0, so op=0 and format=0 present a nop.
  - stall = 0 while reset is high.
  - Reset mid-operation discards any held or in-flight instruction; no partial write.
- Register table write: on posedge, if reg_write_wb=1, table[rt_addr_wb] <= rt_wb.
- Register table read: combinational on dec_ra_addr and dec_rb_addr.
  - Write bypass: if reg_write_wb=1 and rt_addr_wb equals a source address, that source takes rt_wb instead of the table value.
  - Bypass applies to ra and rb independently.
- Hazard detection: a source is live if it is ra, or if it is rb with dec_uses_rb=1. hazard = dec_valid AND a live source matches any of:
  - (a) the output register: rt_addr with reg_write=1;
  - (b) rt_addr_delay[0] with reg_write_delay[0]=1;
  - (c) rt_addr_delay[1] with reg_write_delay[1]=1.
  - Entry delay[2] is covered by the write bypass. delay[3] is already in the table.
- stall = hazard AND NOT branch_taken.
- Output register update on posedge, first matching rule wins:
  1. branch_taken=1 -> load nop: all outputs 0.
  2. dec_valid=0 or hazard=1 -> load nop.
  3. Otherwise capture the dec_* fields, plus ra/rb after bypass.
- Latency: decode cycle t -> Permute inputs valid in cycle t+1 -> Permute result at rt_wb in cycle t+4.
- A back-to-back dependent pair stalls exactly 3 cycles. The dependent instruction issues in the cycle its producer is on the wb port and takes the value via bypass.
- rb is captured even when dec_uses_rb=0; Permute ignores it.
- Simultaneous writeback and hazard check in the same cycle: the writeback never clears hazard (a)-(c). Those entries are strictly younger than wb.
- Two sources equal to the same address are handled identically.

Test Plan:
- Reset, then write r5=0x0123..EF via the wb port, then decode a read of ra=5 with no hazard -> next cycle ra output=0x0123..EF, stall=0 throughout.
- Same-cycle bypass: wb writes r9=0xAA..AA while decode reads ra=9, and table[9]=0 -> captured ra=0xAA..AA.
- Dependent pair, shlqbi r3 then rotqby r4,r3,r2 -> stall high for 3 cycles, 3 nops injected, second instruction issues with ra equal to the first result.
- Format 2 instruction with dec_uses_rb=0 whose rb address matches an in-flight rt -> no stall.
- Flush: branch_taken high while stall=1 -> stall=0 and nop loaded. The held instruction is dropped.
- Assert reset while a dependent pair is stalled -> all outputs 0 immediately without waiting for clk, table reads 0 after release.

Source files
------------

// File: rtl/perm_rf_fwd_if.sv
// Bundle between decode, the Permute pipe and the register-fetch/forward stage.
// master: decode + Permute side. slave: the register-fetch/forward stage.
interface perm_rf_fwd_if #(
   parameter int DATA_W = 128,
   parameter int ADDR_W = 7
);
   // decode -> stage
   logic                   dec_valid;
   logic [10:0]            dec_op;
   logic [2:0]             dec_format;
   logic [ADDR_W-1:0]      dec_rt_addr;
   logic [ADDR_W-1:0]      dec_ra_addr;
   logic [ADDR_W-1:0]      dec_rb_addr;
   logic                   dec_uses_rb;
   logic [17:0]            dec_imm;
   logic                   dec_reg_write;
   logic                   branch_taken;
   // Permute writeback and staging -> stage
   logic [DATA_W-1:0]      rt_wb;
   logic [ADDR_W-1:0]      rt_addr_wb;
   logic                   reg_write_wb;
   logic [3:0][ADDR_W-1:0] rt_addr_delay;
   logic [3:0]             reg_write_delay;
   // stage -> decode / Permute
   logic                   stall;
   logic [10:0]            op;
   logic [2:0]             format;
   logic [ADDR_W-1:0]      rt_addr;
   logic [DATA_W-1:0]      ra;
   logic [DATA_W-1:0]      rb;
   logic [17:0]            imm;
   logic                   reg_write;

   modport master (
      output dec_valid, dec_op, dec_format, dec_rt_addr, dec_ra_addr, dec_rb_addr,
             dec_uses_rb, dec_imm, dec_reg_write, branch_taken,
             rt_wb, rt_addr_wb, reg_write_wb, rt_addr_delay, reg_write_delay,
      input  stall, op, format, rt_addr, ra, rb, imm, reg_write
   );

   modport slave (
      input  dec_valid, dec_op, dec_format, dec_rt_addr, dec_ra_addr, dec_rb_addr,
             dec_uses_rb, dec_imm, dec_reg_write, branch_taken,
             rt_wb, rt_addr_wb, reg_write_wb, rt_addr_delay, reg_write_delay,
      output stall, op, format, rt_addr, ra, rb, imm, reg_write
   );
endinterface

// File: rtl/perm_rf_fwd.sv
// Register-fetch/forward stage in front of the Permute pipe: register table,
// writeback bypass, RAW hazard stall against in-flight Permute results, and
// the registered instruction bundle Permute consumes one cycle later.
module perm_rf_fwd #(
   parameter int NUM_REGS = 128,
   parameter int DATA_W   = 128,
   parameter int ADDR_W   = 7
) (
   input  logic          clk_i,
   input  logic          reset_i,
   perm_rf_fwd_if.slave  bus
);

   logic [DATA_W-1:0] regs_q [NUM_REGS];

   logic [10:0]       op_q,      op_d;
   logic [2:0]        format_q,  format_d;
   logic [ADDR_W-1:0] rt_addr_q, rt_addr_d;
   logic [DATA_W-1:0] ra_q,      ra_d;
   logic [DATA_W-1:0] rb_q,      rb_d;
   logic [17:0]       imm_q,     imm_d;
   logic              reg_write_q, reg_write_d;

   logic [DATA_W-1:0] ra_fwd, rb_fwd;
   logic              ra_busy, rb_busy, hazard;

   // Staging entry 2 coincides with the writeback port (bypass covers it) and
   // entry 3 is already in the table, so neither takes part in hazard checks.
   logic unused_delay;
   assign unused_delay = ^{bus.rt_addr_delay[3], bus.rt_addr_delay[2], bus.reg_write_delay[3:2]};

   // Register table: Permute writeback port, whole table cleared on reset.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      end else if (bus.reg_write_wb) begin
         regs_q[bus.rt_addr_wb] <= bus.rt_wb;
      end
   end

   // Source read with same-cycle writeback bypass, ra and rb independently.
   always_comb begin
      ra_fwd = regs_q[bus.dec_ra_addr];
      rb_fwd = regs_q[bus.dec_rb_addr];
      if (bus.reg_write_wb && (bus.rt_addr_wb == bus.dec_ra_addr)) ra_fwd = bus.rt_wb;
      if (bus.reg_write_wb && (bus.rt_addr_wb == bus.dec_rb_addr)) rb_fwd = bus.rt_wb;
   end

   // A source is busy while a younger-than-writeback producer targets it.
   // The writeback in the same cycle never clears these: they are younger.
   always_comb begin
      ra_busy = (reg_write_q             && (rt_addr_q               == bus.dec_ra_addr)) ||
                (bus.reg_write_delay[0]  && (bus.rt_addr_delay[0]    == bus.dec_ra_addr)) ||
                (bus.reg_write_delay[1]  && (bus.rt_addr_delay[1]    == bus.dec_ra_addr));
      rb_busy = (reg_write_q             && (rt_addr_q               == bus.dec_rb_addr)) ||
                (bus.reg_write_delay[0]  && (bus.rt_addr_delay[0]    == bus.dec_rb_addr)) ||
                (bus.reg_write_delay[1]  && (bus.rt_addr_delay[1]    == bus.dec_rb_addr));
      hazard  = bus.dec_valid && (ra_busy || (bus.dec_uses_rb && rb_busy));
   end

   // A flush overrides the stall; decode is never held while in reset.
   assign bus.stall = hazard && !bus.branch_taken && !reset_i;

   // Next bundle: nop on flush, bubble or hazard, else the decoded instruction.
   always_comb begin
      op_d        = '0;
      format_d    = '0;
      rt_addr_d   = '0;
      ra_d        = '0;
      rb_d        = '0;
      imm_d       = '0;
      reg_write_d = 1'b0;
      if (!bus.branch_taken && bus.dec_valid && !hazard) begin
         op_d        = bus.dec_op;
         format_d    = bus.dec_format;
         rt_addr_d   = bus.dec_rt_addr;
         ra_d        = ra_fwd;
         rb_d        = rb_fwd;
         imm_d       = bus.dec_imm;
         reg_write_d = bus.dec_reg_write;
      end
   end

   // Output register toward Permute; reset presents a nop immediately.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         op_q        <= '0;
         format_q    <= '0;
         rt_addr_q   <= '0;
         ra_q        <= '0;
         rb_q        <= '0;
         imm_q       <= '0;
         reg_write_q <= 1'b0;
      end else begin
         op_q        <= op_d;
         format_q    <= format_d;
         rt_addr_q   <= rt_addr_d;
         ra_q        <= ra_d;
         rb_q        <= rb_d;
         imm_q       <= imm_d;
         reg_write_q <= reg_write_d;
      end
   end

   assign bus.op        = op_q;
   assign bus.format    = format_q;
   assign bus.rt_addr   = rt_addr_q;
   assign bus.ra        = ra_q;
   assign bus.rb        = rb_q;
   assign bus.imm       = imm_q;
   assign bus.reg_write = reg_write_q;

endmodule

// File: tb/tb_perm_rf_fwd.sv
// Bench for perm_rf_fwd: directed scenarios pinned with literal expectations,
// then randomized decode traffic against an architectural reference model.
// The bench also plays the Permute pipe: a bundle issued at one edge shows up
// on the staging entries and returns on the writeback port three cycles later.
module tb_perm_rf_fwd;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   perm_rf_fwd_if bus ();
   perm_rf_fwd dut (.clk_i(clk), .reset_i(reset), .bus(bus));

   int errors = 0;
   int checks = 0;

   // reference state
   logic [127:0] m_tbl [128];
   logic         p_we   [4];
   logic [6:0]   p_addr [4];
   logic [127:0] p_data [4];
   logic [10:0]  e_op;
   logic [2:0]   e_fmt;
   logic [6:0]   e_rt;
   logic [127:0] e_ra, e_rb;
   logic [17:0]  e_imm;
   logic         e_we;
   logic         ovr_we = 1'b0;
   logic [6:0]   ovr_addr = '0;
   logic [127:0] ovr_data = '0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // What the Permute pipe makes of a bundle.
   function automatic logic [127:0] perm_f(input logic [10:0] op, input logic [127:0] a, input logic [127:0] b);
      return a ^ {b[63:0], b[127:64]} ^ {117'd0, op};
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 128; i++) m_tbl[i] = '0;
      for (int i = 0; i < 4; i++) begin p_we[i] = 1'b0; p_addr[i] = '0; p_data[i] = '0; end
      e_op = '0; e_fmt = '0; e_rt = '0; e_ra = '0; e_rb = '0; e_imm = '0; e_we = 1'b0;
      ovr_we = 1'b0;
   endtask

   task automatic drive_env();
      for (int i = 0; i < 4; i++) begin
         bus.rt_addr_delay[i]   = p_addr[i];
         bus.reg_write_delay[i] = p_we[i];
      end
      if (ovr_we) begin
         bus.reg_write_wb = 1'b1; bus.rt_addr_wb = ovr_addr; bus.rt_wb = ovr_data;
      end else begin
         bus.reg_write_wb = p_we[2]; bus.rt_addr_wb = p_addr[2]; bus.rt_wb = p_data[2];
      end
   endtask

   function automatic logic pending(input logic [6:0] a);
      return (e_we && e_rt == a) || (p_we[0] && p_addr[0] == a) || (p_we[1] && p_addr[1] == a);
   endfunction

   function automatic logic [127:0] rd(input logic [6:0] a);
      if (bus.reg_write_wb && bus.rt_addr_wb == a) return bus.rt_wb;
      return m_tbl[a];
   endfunction

   // One clock cycle: compare at negedge, then advance the model across the edge.
   task automatic tick(output logic s);
      logic haz, st;
      logic [10:0] n_op; logic [2:0] n_fmt; logic [6:0] n_rt;
      logic [127:0] n_ra, n_rb; logic [17:0] n_imm; logic n_we;
      drive_env();
      @(negedge clk);
      haz = bus.dec_valid && (pending(bus.dec_ra_addr) || (bus.dec_uses_rb && pending(bus.dec_rb_addr)));
      st  = haz && !bus.branch_taken;
      check("stall",     128'(bus.stall),     128'(st));
      check("op",        128'(bus.op),        128'(e_op));
      check("format",    128'(bus.format),    128'(e_fmt));
      check("rt_addr",   128'(bus.rt_addr),   128'(e_rt));
      check("ra",        bus.ra,              e_ra);
      check("rb",        bus.rb,              e_rb);
      check("imm",       128'(bus.imm),       128'(e_imm));
      check("reg_write", 128'(bus.reg_write), 128'(e_we));
      s = bus.stall;
      n_op = '0; n_fmt = '0; n_rt = '0; n_ra = '0; n_rb = '0; n_imm = '0; n_we = 1'b0;
      if (!bus.branch_taken && bus.dec_valid && !haz) begin
         n_op = bus.dec_op; n_fmt = bus.dec_format; n_rt = bus.dec_rt_addr;
         n_ra = rd(bus.dec_ra_addr); n_rb = rd(bus.dec_rb_addr);
         n_imm = bus.dec_imm; n_we = bus.dec_reg_write;
      end
      @(posedge clk);
      if (bus.reg_write_wb) m_tbl[bus.rt_addr_wb] = bus.rt_wb;
      for (int i = 3; i > 0; i--) begin
         p_we[i] = p_we[i-1]; p_addr[i] = p_addr[i-1]; p_data[i] = p_data[i-1];
      end
      p_we[0] = e_we; p_addr[0] = e_rt; p_data[0] = perm_f(e_op, e_ra, e_rb);
      e_op = n_op; e_fmt = n_fmt; e_rt = n_rt; e_ra = n_ra; e_rb = n_rb; e_imm = n_imm; e_we = n_we;
      #1;
   endtask

   task automatic decode(input logic v, input logic [10:0] op, input logic [2:0] fmt,
                         input logic [6:0] rt, input logic [6:0] ra, input logic [6:0] rb,
                         input logic urb, input logic we);
      bus.dec_valid = v; bus.dec_op = op; bus.dec_format = fmt; bus.dec_rt_addr = rt;
      bus.dec_ra_addr = ra; bus.dec_rb_addr = rb; bus.dec_uses_rb = urb;
      bus.dec_imm = 18'h2A5A5; bus.dec_reg_write = we;
   endtask

   initial begin
      logic s;
      int n;
      model_clear();
      bus.branch_taken = 1'b0;
      // In reset with a decode that would hazard against staging entry 0.
      decode(1'b1, 11'h1DB, 3'd1, 7'd3, 7'd1, 7'd2, 1'b1, 1'b1);
      for (int i = 0; i < 4; i++) begin bus.rt_addr_delay[i] = 7'd1; bus.reg_write_delay[i] = 1'b1; end
      bus.reg_write_wb = 1'b0; bus.rt_addr_wb = '0; bus.rt_wb = '0;
      #12;
      check("rst_stall", 128'(bus.stall), 128'(0));
      check("rst_op",    128'(bus.op),    128'(0));
      check("rst_ra",    bus.ra,          128'(0));
      @(posedge clk); #1;
      reset = 1'b0;

      // Writeback then plain read of r5.
      decode(1'b0, 11'h0, 3'd0, 7'd0, 7'd0, 7'd0, 1'b0, 1'b0);
      ovr_we = 1'b1; ovr_addr = 7'd5; ovr_data = 128'h0123456789ABCDEF0123456789ABCDEF;
      tick(s);
      ovr_we = 1'b0;
      decode(1'b1, 11'h1DC, 3'd1, 7'd8, 7'd5, 7'd0, 1'b1, 1'b0);
      tick(s);
      check("t1_stall", 128'(s), 128'(0));
      check("t1_ra", bus.ra, 128'h0123456789ABCDEF0123456789ABCDEF);

      // Same-cycle bypass from the writeback port.
      ovr_we = 1'b1; ovr_addr = 7'd9; ovr_data = {16{8'hAA}};
      decode(1'b1, 11'h1DC, 3'd1, 7'd8, 7'd9, 7'd0, 1'b1, 1'b0);
      tick(s);
      ovr_we = 1'b0;
      check("t2_bypass_ra", bus.ra, {16{8'hAA}});

      // shlqbi r3,r1,r2 then rotqby r4,r3,r2.
      decode(1'b1, 11'h1DB, 3'd1, 7'd3, 7'd1, 7'd2, 1'b1, 1'b1);
      tick(s);
      decode(1'b1, 11'h1DC, 3'd1, 7'd4, 7'd3, 7'd2, 1'b1, 1'b1);
      n = 0;
      for (int i = 0; i < 10; i++) begin
         tick(s);
         if (!s) break;
         n++;
      end
      check("t3_stall_cycles", 128'(n), 128'(3));
      check("t3_dep_ra", bus.ra, 128'h1DB);
      check("t3_dep_op", 128'(bus.op), 128'h1DC);

      // Format 2: rb unused, so a matching in-flight rt must not stall.
      decode(1'b1, 11'h0A1, 3'd1, 7'd6, 7'd0, 7'd0, 1'b1, 1'b1);
      tick(s);
      decode(1'b1, 11'h0A2, 3'd2, 7'd10, 7'd0, 7'd6, 1'b0, 1'b1);
      tick(s);
      check("t4_fmt2_stall", 128'(s), 128'(0));

      // Flush during a stall.
      decode(1'b1, 11'h0B1, 3'd1, 7'd7, 7'd0, 7'd0, 1'b1, 1'b1);
      tick(s);
      decode(1'b1, 11'h0B2, 3'd1, 7'd11, 7'd7, 7'd0, 1'b1, 1'b1);
      tick(s);
      check("t5_stall_before", 128'(s), 128'(1));
      bus.branch_taken = 1'b1;
      tick(s);
      check("t5_stall_flush", 128'(s), 128'(0));
      check("t5_nop_op", 128'(bus.op), 128'(0));
      bus.branch_taken = 1'b0;
      decode(1'b0, 11'h0, 3'd0, 7'd0, 7'd0, 7'd0, 1'b0, 1'b0);
      repeat (4) tick(s);

      // Reset while a dependent pair is stalled.
      decode(1'b1, 11'h0C1, 3'd1, 7'd12, 7'd0, 7'd0, 1'b1, 1'b1);
      tick(s);
      decode(1'b1, 11'h0C2, 3'd1, 7'd13, 7'd12, 7'd0, 1'b1, 1'b1);
      drive_env();
      #1;
      check("t6_stalled", 128'(bus.stall), 128'(1));
      check("t6_op_before", 128'(bus.op), 128'h0C1);
      #1 reset = 1'b1;
      #1;
      check("t6_async_op", 128'(bus.op), 128'(0));
      check("t6_async_we", 128'(bus.reg_write), 128'(0));
      check("t6_async_stall", 128'(bus.stall), 128'(0));
      model_clear();
      @(posedge clk); #1;
      reset = 1'b0;
      decode(1'b1, 11'h0C3, 3'd1, 7'd14, 7'd3, 7'd5, 1'b1, 1'b0);
      tick(s);
      check("t6_tbl_r3", bus.ra, 128'(0));
      check("t6_tbl_r5", bus.rb, 128'(0));

      // Randomized traffic; decode holds its instruction while stalled.
      s = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         if (!s) begin
            logic [2:0] f;
            f = 3'($urandom_range(0, 7));
            decode(($urandom_range(0, 3) != 0), 11'($urandom), f,
                   7'($urandom_range(0, 7)), 7'($urandom_range(0, 7)), 7'($urandom_range(0, 7)),
                   (f == 3'd2) ? 1'b0 : 1'($urandom), 1'($urandom));
            bus.dec_imm = 18'($urandom);
         end
         bus.branch_taken = ($urandom_range(0, 11) == 0);
         tick(s);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
